exc_unit: RTL and testbench

EXC_UNIT -- requirements
Module: exc_unit

---
 rtl/exc_unit.sv | 125 ++++++++++++
 tb/tb_exc_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/exc_unit.sv
// Exception/interrupt unit: IRQ synchronizer with edge-detected pending flag,
// IDLE/HANDLER/FATAL state machine, saved return address/cause and a saturating exception counter.
module exc_unit #(
    parameter int unsigned N           = 64,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [63:0] VECTOR      = 64'hD8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         IRQ,
    input  logic         Exc,
    input  logic         ERet,
    input  logic [3:0]   Status,
    input  logic [N-1:0] PC,
    output logic         ExtIRQ,
    output logic [N-1:0] ExcPC,
    output logic [N-1:0] ELR,
    output logic [3:0]   ESR,
    output logic         InHandler,
    output logic         Halt,
    output logic [7:0]   ExcCount
);

    localparam int unsigned CAUSE_W = 4;
    localparam int unsigned CNT_W   = 8;
    localparam logic [CAUSE_W-1:0] CAUSE_IRQ = CAUSE_W'(4'b0001);
    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(8'hFF);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HANDLER = 2'd1,
        FATAL   = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   irq_prev_q, irq_prev_d;
    logic                   pending_q, pending_d;
    logic [N-1:0]           elr_q, elr_d;
    logic [CAUSE_W-1:0]     esr_q, esr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   irq_edge;
    logic [CNT_W-1:0]       cnt_inc;

    // Synchronizer shift plus one extra stage so the edge is seen between two settled samples
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], IRQ};
        irq_prev_d = sync_q[SYNC_STAGES-1];
        irq_edge   = sync_q[SYNC_STAGES-1] & ~irq_prev_q;
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        elr_d     = elr_q;
        esr_d     = esr_q;
        cnt_d     = cnt_q;
        cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

        unique case (state_q)
            IDLE: begin
                if (Exc) begin
                    state_d = HANDLER;
                    elr_d   = PC;
                    esr_d   = Status;
                    cnt_d   = cnt_inc;
                    if (Status == CAUSE_IRQ) begin
                        pending_d = 1'b0;
                    end
                end
            end
            HANDLER: begin
                // Nested exception wins over a simultaneous ERET; ELR keeps the first return address
                if (Exc) begin
                    state_d = FATAL;
                    esr_d   = Status;
                    cnt_d   = cnt_inc;
                end else if (ERet) begin
                    state_d = IDLE;
                end
            end
            FATAL: begin
                state_d = FATAL;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new edge overrides the clear from an IRQ exception taken in the same cycle
        if (irq_edge && (state_q != FATAL)) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            irq_prev_q <= 1'b0;
            pending_q  <= 1'b0;
            elr_q      <= '0;
            esr_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            irq_prev_q <= irq_prev_d;
            pending_q  <= pending_d;
            elr_q      <= elr_d;
            esr_q      <= esr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Output decode straight from registers, so ExtIRQ has no path from Exc
    assign ExtIRQ    = pending_q & (state_q == IDLE);
    assign InHandler = (state_q == HANDLER);
    assign Halt      = (state_q == FATAL);
    assign ExcPC     = N'(VECTOR);
    assign ELR       = elr_q;
    assign ESR       = esr_q;
    assign ExcCount  = cnt_q;

endmodule

// File: tb/tb_exc_unit.sv
// Directed bench for exc_unit: expected outputs are queued with each step and
// popped/compared after the following clock edge (or immediately for async reset).
module tb_exc_unit;

    localparam int unsigned N = 64;
    localparam logic [63:0] VEC = 64'hD8;

    logic         clk;
    logic         reset;
    logic         irq;
    logic         exc;
    logic         eret;
    logic [3:0]   status;
    logic [N-1:0] pc;
    logic         ext_irq;
    logic [N-1:0] exc_pc;
    logic [N-1:0] elr;
    logic [3:0]   esr;
    logic         in_handler;
    logic         halt;
    logic [7:0]   exc_count;

    exc_unit #(.N(N), .SYNC_STAGES(2), .VECTOR(VEC)) dut (
        .clk      (clk),
        .reset    (reset),
        .IRQ      (irq),
        .Exc      (exc),
        .ERet     (eret),
        .Status   (status),
        .PC       (pc),
        .ExtIRQ   (ext_irq),
        .ExcPC    (exc_pc),
        .ELR      (elr),
        .ESR      (esr),
        .InHandler(in_handler),
        .Halt     (halt),
        .ExcCount (exc_count)
    );

    typedef struct {
        string        tag;
        logic         ext;
        logic [N-1:0] elr;
        logic [3:0]   esr;
        logic         inh;
        logic         halt;
        logic [7:0]   cnt;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input string field, input logic [63:0] obs, input logic [63:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp_v);
        end
    endtask

    task automatic drive(input logic i, input logic e, input logic r, input logic [3:0] st, input logic [N-1:0] p);
        irq    = i;
        exc    = e;
        eret   = r;
        status = st;
        pc     = p;
    endtask

    task automatic expect_out(input string tag, input logic ext_e, input logic [N-1:0] elr_e, input logic [3:0] esr_e,
                              input logic inh_e, input logic halt_e, input logic [7:0] cnt_e);
        exp_t x;
        x.tag  = tag;
        x.ext  = ext_e;
        x.elr  = elr_e;
        x.esr  = esr_e;
        x.inh  = inh_e;
        x.halt = halt_e;
        x.cnt  = cnt_e;
        sb.push_back(x);
    endtask

    task automatic check_out();
        exp_t x;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard observed=empty expected=entry");
            return;
        end
        x = sb.pop_front();
        cmp(x.tag, "ExtIRQ",    64'(ext_irq),    64'(x.ext));
        cmp(x.tag, "ELR",       64'(elr),        64'(x.elr));
        cmp(x.tag, "ESR",       64'(esr),        64'(x.esr));
        cmp(x.tag, "InHandler", 64'(in_handler), 64'(x.inh));
        cmp(x.tag, "Halt",      64'(halt),       64'(x.halt));
        cmp(x.tag, "ExcCount",  64'(exc_count),  64'(x.cnt));
        cmp(x.tag, "ExcPC",     64'(exc_pc),     VEC);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c;

        // Asynchronous reset with no clock edge yet
        reset = 1'b1;
        drive(0, 0, 0, 4'd0, '0);
        #1 reset = 1'b0;
        #2;
        expect_out("reset_async", 0, '0, 4'd0, 0, 0, 8'd0);
        check_out();
        @(posedge clk);
        #1 reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 4'd0, '0);
            expect_out("idle_after_reset", 0, '0, 4'd0, 0, 0, 8'd0);
            tick();
        end

        // IRQ pulse, 3 cycles high: ExtIRQ appears SYNC_STAGES+1 edges later
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 4'd0, N'(64'h40));
            expect_out("irq_latency", (k == 2), '0, 4'd0, 0, 0, 8'd0);
            tick();
        end
        drive(0, 1, 0, 4'b0001, N'(64'h40));
        expect_out("take_irq", 0, N'(64'h40), 4'b0001, 1, 0, 8'd1);
        tick();
        drive(0, 0, 1, 4'd0, N'(64'h44));
        expect_out("eret_irq", 0, N'(64'h40), 4'b0001, 0, 0, 8'd1);
        tick();

        // IRQ arriving during a handler is held until return
        drive(0, 1, 0, 4'b0010, N'(64'h60));
        expect_out("take_invop", 0, N'(64'h60), 4'b0010, 1, 0, 8'd2);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 4'd0, N'(64'h64));
            expect_out("irq_in_handler", 0, N'(64'h60), 4'b0010, 1, 0, 8'd2);
            tick();
        end
        drive(0, 0, 1, 4'd0, N'(64'h64));
        expect_out("eret_then_extirq", 1, N'(64'h60), 4'b0010, 0, 0, 8'd2);
        tick();

        // Non-IRQ exception leaves Pending alone
        drive(0, 1, 0, 4'b0010, N'(64'h70));
        expect_out("invop_keeps_pending", 0, N'(64'h70), 4'b0010, 1, 0, 8'd3);
        tick();
        drive(0, 0, 1, 4'd0, N'(64'h74));
        expect_out("pending_survives", 1, N'(64'h70), 4'b0010, 0, 0, 8'd3);
        tick();

        // New IRQ edge coincides with the IRQ exception clearing Pending
        for (int k = 0; k < 2; k++) begin
            drive(1, 0, 0, 4'd0, N'(64'h88));
            expect_out("irq_edge_setup", 1, N'(64'h70), 4'b0010, 0, 0, 8'd3);
            tick();
        end
        drive(1, 1, 0, 4'b0001, N'(64'h90));
        expect_out("set_beats_clear", 0, N'(64'h90), 4'b0001, 1, 0, 8'd4);
        tick();
        drive(0, 0, 1, 4'd0, N'(64'h94));
        expect_out("set_beats_clear_eret", 1, N'(64'h90), 4'b0001, 0, 0, 8'd4);
        tick();

        // Nested invalid opcode (with simultaneous ERET) goes FATAL and freezes
        drive(0, 1, 0, 4'b0010, N'(64'h80));
        expect_out("fatal_first", 0, N'(64'h80), 4'b0010, 1, 0, 8'd5);
        tick();
        drive(0, 1, 1, 4'b0010, N'(64'hD8));
        expect_out("fatal_nested", 0, N'(64'h80), 4'b0010, 0, 1, 8'd6);
        tick();
        for (int k = 0; k < 8; k++) begin
            drive((k < 4), k[0], 1, 4'b0001, N'(64'h100));
            expect_out("fatal_hold", 0, N'(64'h80), 4'b0010, 0, 1, 8'd6);
            tick();
        end

        // Reset out of FATAL, checked before any further clock edge
        #2 reset = 1'b0;
        #1;
        expect_out("reset_from_fatal", 0, '0, 4'd0, 0, 0, 8'd0);
        check_out();
        @(posedge clk);
        #1 reset = 1'b1;
        drive(0, 0, 0, 4'd0, '0);
        expect_out("idle_after_fatal_reset", 0, '0, 4'd0, 0, 0, 8'd0);
        tick();

        // 300 exception/return pairs: counter saturates at 0xFF
        for (int i = 0; i < 300; i++) begin
            c = (i + 1 > 255) ? 255 : i + 1;
            drive(0, 1, 0, 4'b0010, N'(i * 4));
            expect_out("count_exc", 0, N'(i * 4), 4'b0010, 1, 0, 8'(c));
            tick();
            drive(0, 0, 1, 4'd0, '0);
            expect_out("count_eret", 0, N'(i * 4), 4'b0010, 0, 0, 8'(c));
            tick();
        end
        drive(0, 1, 0, 4'b0001, N'(64'h123));
        expect_out("saturated_enter", 0, N'(64'h123), 4'b0001, 1, 0, 8'hFF);
        tick();

        // Reset mid-handler clears everything without a clock edge
        #2 reset = 1'b0;
        #1;
        expect_out("reset_mid_handler", 0, '0, 4'd0, 0, 0, 8'd0);
        check_out();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
